chk_engine_arbiter: RTL and testbench
=====================================

Name: chk_engine_arbiter

Overview:
Packet-granular round-robin arbiter that shares one checksum engine (512-bit AXI4-Stream with tid) among N_REQ host streams. It sits between the per-requester input FIFOs and the duplicate/checksum path. A grant is never changed mid-packet. A source index travels alongside each packet so the return path can route the checksum back to the right requester.

Parameters:
N_REQ, 2, number of requester streams (2..8)
DATA_W, 512, tdata width in bits
ID_W, 6, tid width
WDOG_CYCLES, 1024, mid-packet stall limit; used only with the optional feature

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-low
s_tvalid  in  N_REQ  per-requester valid
s_tready  out  N_REQ  per-requester ready
s_tdata  in  N_REQ*DATA_W  packed data; requester i occupies slice i
s_tkeep  in  N_REQ*DATA_W/8  packed keep
s_tid  in  N_REQ*ID_W  packed id
s_tlast  in  N_REQ  per-requester last
m_tvalid  out  1  to checksum engine
m_tready  in  1  from checksum engine
m_tdata  out  DATA_W  granted data
m_tkeep  out  DATA_W/8  granted keep
m_tid  out  ID_W  granted id, unmodified
m_tlast  out  1  granted last
m_src  out  clog2(N_REQ)  index of the granted requester; stable for the whole packet
busy  out  1  high while in XFER
pkt_done  out  1  one-cycle pulse on the accepted tlast beat
wdog_err  out  1  sticky stall-abort flag; exists only with the optional feature

Behaviour:
- Reset (areset low, asynchronous):
  - state=IDLE, rr_ptr=0, m_src=0.
  - All s_tready=0; m_tvalid=0, busy=0, pkt_done=0, wdog_err=0.
- State machine: IDLE -> XFER -> IDLE.
- IDLE:
  - All s_tready=0 and m_tvalid=0.
  - If any s_tvalid is high, pick the first valid requester starting at rr_ptr and going upward (wrapping modulo N_REQ).
  - Register the choice in gnt and m_src, then go to XFER on the next edge.
  - Cost: exactly one bubble cycle per packet.
- XFER:
  - Combinational pass-through from the granted requester: m_tvalid=s_tvalid[gnt], m_tdata/m_tkeep/m_tid/m_tlast from slice gnt.
  - s_tready[gnt]=m_tready; every other s_tready=0.
  - Zero-cycle forward latency; no data buffering.
- Beat transfer occurs when m_tvalid && m_tready.
- On a transfer with m_tlast=1:
  - pkt_done=1 for that cycle.
  - rr_ptr=(gnt+1) mod N_REQ.
  - Next state IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
  - Maximum wait is (N_REQ-1) packets.
- A requester dropping tvalid mid-packet keeps the grant; the block waits indefinitely unless the optional feature is enabled.
- Single-beat packet (tlast on the first beat): XFER lasts one cycle if m_tready=1.
- m_tready held low: all outputs stay stable (AXI rule); no state change.
- Requester raises tvalid in the same cycle another packet's tlast is accepted: it is considered in the next IDLE cycle, using the updated rr_ptr.
- Reset mid-packet: the grant is dropped immediately. The downstream engine must also be reset; no partial-packet recovery is performed.
- rr_ptr width is clog2(N_REQ); wrap is explicit (not power-of-two reliant) for N_REQ=3,5,6,7.

Optional Feature:
Macro CHK_ARB_WATCHDOG_EN.
- With it:
  - In XFER, a counter increments each cycle that s_tvalid[gnt]=0 and clears on any granted beat.
  - On reaching WDOG_CYCLES, the block emits one forced beat: m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0, m_tid from the last accepted beat.
  - Once that beat is accepted: wdog_err is set (sticky until reset), rr_ptr advances, state returns to IDLE.
  - The stalled requester's remaining beats are then arbitrated as a new packet.
- Without it: no counter logic, the wdog_err port is absent, and a stall holds the grant forever.

Test Plan:
- N_REQ=2, requester 0 sends a 4-beat packet, m_tready=1 -> 1 idle cycle, 4 beats with m_src=0, pkt_done pulse on beat 4, busy high for 4 cycles.
- Both requesters continuously valid, 3 packets each of 2 beats -> m_src sequence 0,1,0,1,0,1; each packet preceded by one bubble cycle.
- m_tready toggles 1,0,1,0 during a 3-beat packet -> data beats unchanged across stalls, exactly 3 transfers, s_tready[1] stays 0 throughout.
- N_REQ=3, rr_ptr=2 (after a requester-1 packet), requesters 0 and 2 both valid -> requester 2 granted first, then requester 0.
- areset asserted on beat 2 of 4 -> next cycle all outputs at reset values, rr_ptr=0; after release, requester 0 is re-granted from the start of its packet.
- CHK_ARB_WATCHDOG_EN, WDOG_CYCLES=16, requester 0 sends beat 1 then drops tvalid for 20 cycles -> after 16 idle cycles a forced beat with tlast=1 and tkeep=0 is emitted, wdog_err=1, requester 1 is granted next.

Source files
------------

// File: rtl/chk_engine_arbiter_if.sv
// AXI4-Stream bundle with LANES parallel streams packed side by side.
// Lane i occupies slice i of tdata/tkeep/tid.
interface chk_engine_arbiter_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 512,
  parameter int ID_W   = 6
);
  logic [LANES-1:0]          tvalid;
  logic [LANES-1:0]          tready;
  logic [LANES*DATA_W-1:0]   tdata;
  logic [LANES*DATA_W/8-1:0] tkeep;
  logic [LANES*ID_W-1:0]     tid;
  logic [LANES-1:0]          tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tlast,
    output tready
  );
endinterface

// File: rtl/chk_engine_arbiter.sv
// Packet-granular round-robin arbiter feeding one checksum engine.
// Optional mid-packet stall watchdog: define CHK_ARB_WATCHDOG_EN.
module chk_engine_arbiter #(
  parameter int N_REQ       = 2,
  parameter int DATA_W      = 512,
  parameter int ID_W        = 6,
  parameter int WDOG_CYCLES = 1024,
  localparam int SRC_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               aclk,
  input  logic               areset,
  chk_engine_arbiter_if.slave  s,
  chk_engine_arbiter_if.master m,
  output logic [SRC_W-1:0]   m_src,
  output logic               busy,
  output logic               pkt_done
`ifdef CHK_ARB_WATCHDOG_EN
  ,
  output logic               wdog_err
`endif
);

  localparam int KW = DATA_W / 8;

  typedef enum logic {
    IDLE,
    XFER
  } state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] gnt_q, gnt_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [SRC_W-1:0] pick;
  logic             any_v;
  logic             vld_c;
  logic             last_c;
  logic             fire_c;
  logic             wd_hit;

  logic [DATA_W-1:0] lane_data [N_REQ];
  logic [KW-1:0]     lane_keep [N_REQ];
  logic [ID_W-1:0]   lane_tid  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane_data[g] = s.tdata[g*DATA_W +: DATA_W];
    assign lane_keep[g] = s.tkeep[g*KW +: KW];
    assign lane_tid[g]  = s.tid[g*ID_W +: ID_W];
  end

`ifdef CHK_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [ID_W-1:0]  last_tid_q, last_tid_d;
  logic             wdog_err_q, wdog_err_d;

  assign wd_hit   = (state_q == XFER) &&
                    (wd_cnt_q == CNT_W'(WDOG_CYCLES));
  assign wdog_err = wdog_err_q;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;

  assign wd_hit = 1'b0;
`endif

  // Scan downward so the lowest offset from rr_q wins; wrap is explicit.
  always_comb begin
    logic [SRC_W-1:0] idx;
    int k;
    pick  = '0;
    any_v = 1'b0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(rr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      idx = SRC_W'(k);
      if (s.tvalid[idx]) begin
        pick  = idx;
        any_v = 1'b1;
      end
    end
  end

  always_comb begin
    vld_c    = 1'b0;
    last_c   = s.tlast[gnt_q];
    s.tready = '0;
    m.tdata  = lane_data[gnt_q];
    m.tkeep  = lane_keep[gnt_q];
    m.tid    = lane_tid[gnt_q];
    if (state_q == XFER) begin
      vld_c           = s.tvalid[gnt_q];
      s.tready[gnt_q] = m.tready;
    end
`ifdef CHK_ARB_WATCHDOG_EN
    if (wd_hit) begin
      vld_c    = 1'b1;
      last_c   = 1'b1;
      m.tdata  = '0;
      m.tkeep  = '0;
      m.tid    = last_tid_q;
      s.tready = '0;
    end
`endif
    m.tvalid = vld_c;
    m.tlast  = last_c;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    fire_c   = (state_q == XFER) && vld_c && m.tready;
    pkt_done = fire_c && last_c;
    unique case (1'b1)
      state_q == IDLE: begin
        if (any_v) begin
          state_d = XFER;
          gnt_d   = pick;
        end
      end
      state_q == XFER: begin
        if (pkt_done) begin
          state_d = IDLE;
          rr_d    = (gnt_q == SRC_W'(N_REQ - 1)) ?
                    '0 : gnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef CHK_ARB_WATCHDOG_EN
  // Forced beat holds the count saturated until the engine takes it.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    last_tid_d = last_tid_q;
    wdog_err_d = wdog_err_q;
    if (state_q != XFER) begin
      wd_cnt_d = '0;
    end else if (fire_c && !wd_hit) begin
      wd_cnt_d   = '0;
      last_tid_d = lane_tid[gnt_q];
    end else if (!s.tvalid[gnt_q] && !wd_hit) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (fire_c && wd_hit) wdog_err_d = 1'b1;
  end
`endif

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
`ifdef CHK_ARB_WATCHDOG_EN
      wd_cnt_q   <= '0;
      last_tid_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
`ifdef CHK_ARB_WATCHDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      last_tid_q <= last_tid_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign m_src = gnt_q;
  assign busy  = (state_q == XFER);

endmodule

// File: tb/tb_chk_engine_arbiter.sv
// Directed-vector bench for chk_engine_arbiter (N_REQ=2 and N_REQ=3).
// Watchdog vectors run only when CHK_ARB_WATCHDOG_EN is defined.
module tb_chk_engine_arbiter;

  localparam int DW = 512;
  localparam int IW = 6;
  localparam int WD = 16;

  logic aclk = 1'b0;
  logic areset = 1'b0;

  always #5 aclk = ~aclk;

  chk_engine_arbiter_if #(.LANES(2), .DATA_W(DW), .ID_W(IW)) s2 ();
  chk_engine_arbiter_if #(.LANES(1), .DATA_W(DW), .ID_W(IW)) m2 ();
  chk_engine_arbiter_if #(.LANES(3), .DATA_W(DW), .ID_W(IW)) s3 ();
  chk_engine_arbiter_if #(.LANES(1), .DATA_W(DW), .ID_W(IW)) m3 ();

  logic       m_src2;
  logic       busy2;
  logic       done2;
  logic [1:0] m_src3;
  logic       busy3;
  logic       done3;
`ifdef CHK_ARB_WATCHDOG_EN
  logic       wdog_err2;
  logic       wdog_err3;
`endif

  chk_engine_arbiter #(
    .N_REQ(2), .DATA_W(DW), .ID_W(IW), .WDOG_CYCLES(WD)
  ) u2 (
    .aclk(aclk), .areset(areset), .s(s2), .m(m2),
    .m_src(m_src2), .busy(busy2), .pkt_done(done2)
`ifdef CHK_ARB_WATCHDOG_EN
    , .wdog_err(wdog_err2)
`endif
  );

  chk_engine_arbiter #(
    .N_REQ(3), .DATA_W(DW), .ID_W(IW), .WDOG_CYCLES(WD)
  ) u3 (
    .aclk(aclk), .areset(areset), .s(s3), .m(m3),
    .m_src(m_src3), .busy(busy3), .pkt_done(done3)
`ifdef CHK_ARB_WATCHDOG_EN
    , .wdog_err(wdog_err3)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  int pkts [2];
  int len  [2];
  int bidx [2];
  bit en   [2];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(int r, int b);
    return DW'(64'hC0DE_0000_0000_0000 | 64'(r << 8) | 64'(b));
  endfunction

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      s2.tvalid[r]             = en[r] && (pkts[r] > 0);
      s2.tdata[r*DW +: DW]     = beat_data(r, bidx[r]);
      s2.tkeep[r*DW/8 +: DW/8] = '1;
      s2.tid[r*IW +: IW]       = IW'(r + 5);
      s2.tlast[r]              = (bidx[r] == len[r] - 1);
    end
  endtask

  task automatic step();
    logic [1:0] f;
    f = s2.tvalid & s2.tready;
    @(posedge aclk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (f[r]) begin
        if (bidx[r] == len[r] - 1) begin
          bidx[r] = 0;
          pkts[r]--;
        end else begin
          bidx[r]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pkts[r] = 0;
      len[r]  = 1;
      bidx[r] = 0;
      en[r]   = 1'b1;
    end
    drive();
    m2.tready = 1'b1;
    s3.tvalid = '0;
    s3.tlast  = '1;
    s3.tkeep  = '1;
    for (int r = 0; r < 3; r++) begin
      s3.tdata[r*DW +: DW] = beat_data(r, 0);
      s3.tid[r*IW +: IW]   = IW'(r + 5);
    end
    m3.tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
  endtask

  initial begin
    logic [DW-1:0] e;
    logic [DW-1:0] held;
    bit   rdy [5];
    int   bx  [5];
    int   xfers;
    rdy = '{1, 0, 1, 0, 1};
    bx  = '{0, 1, 1, 2, 2};

    // Reset values
    do_reset();
    check("rst busy", busy2, 0);
    check("rst tvalid", m2.tvalid, 0);
    check("rst tready", s2.tready, 0);
    check("rst done", done2, 0);
    check("rst m_src", m_src2, 0);
    check("rst busy3", busy3, 0);
`ifdef CHK_ARB_WATCHDOG_EN
    check("rst wdog", wdog_err2, 0);
`endif

    // Single requester, 4-beat packet
    pkts[0] = 1;
    len[0]  = 4;
    drive();
    #1;
    check("t1 bubble tvalid", m2.tvalid, 0);
    check("t1 bubble tready", s2.tready, 0);
    step();
    for (int b = 0; b < 4; b++) begin
      e = beat_data(0, b);
      check("t1 busy", busy2, 1);
      check("t1 tvalid", m2.tvalid, 1);
      check("t1 m_src", m_src2, 0);
      check("t1 data", m2.tdata[63:0], e[63:0]);
      check("t1 tid", m2.tid, 5);
      check("t1 tlast", m2.tlast, (b == 3));
      check("t1 done", done2, (b == 3));
      check("t1 tready", s2.tready, 2'b01);
      step();
    end
    check("t1 busy end", busy2, 0);
    check("t1 tvalid end", m2.tvalid, 0);

    // Round-robin rotation, 3 packets each
    do_reset();
    pkts[0] = 3;
    pkts[1] = 3;
    len[0]  = 2;
    len[1]  = 2;
    drive();
    #1;
    for (int p = 0; p < 6; p++) begin
      check("t2 bubble", m2.tvalid, 0);
      check("t2 bubble busy", busy2, 0);
      step();
      for (int b = 0; b < 2; b++) begin
        e = beat_data(p % 2, b);
        check("t2 m_src", m_src2, p % 2);
        check("t2 data", m2.tdata[63:0], e[63:0]);
        check("t2 done", done2, (b == 1));
        step();
      end
    end

    // Backpressure on a 3-beat packet
    do_reset();
    pkts[0] = 1;
    len[0]  = 3;
    pkts[1] = 1;
    len[1]  = 1;
    drive();
    #1;
    step();
    xfers = 0;
    held  = '0;
    for (int k = 0; k < 5; k++) begin
      m2.tready = rdy[k];
      #1;
      e = beat_data(0, bx[k]);
      check("t3 tvalid", m2.tvalid, 1);
      check("t3 data", m2.tdata[63:0], e[63:0]);
      if (k > 0 && !rdy[k-1]) begin
        check("t3 held", m2.tdata[63:0], held[63:0]);
      end
      check("t3 tready1", s2.tready[1], 0);
      check("t3 tready0", s2.tready[0], rdy[k]);
      check("t3 done", done2, (k == 4));
      if (m2.tvalid && m2.tready) xfers++;
      held = m2.tdata;
      step();
    end
    m2.tready = 1'b1;
    #1;
    check("t3 xfers", 64'(xfers), 3);
    check("t3 busy end", busy2, 0);
    step();
    check("t3 next src", m_src2, 1);
    step();

    // N_REQ=3 wrap: req1, then req2 before req0
    do_reset();
    s3.tvalid = 3'b010;
    #1;
    check("t4 bubble", m3.tvalid, 0);
    step();
    check("t4 src a", m_src3, 1);
    check("t4 done a", done3, 1);
    step();
    s3.tvalid = 3'b101;
    #1;
    check("t4 bubble b", m3.tvalid, 0);
    step();
    e = beat_data(2, 0);
    check("t4 src b", m_src3, 2);
    check("t4 data b", m3.tdata[63:0], e[63:0]);
    check("t4 tready b", s3.tready, 3'b100);
    step();
    s3.tvalid = 3'b001;
    #1;
    step();
    e = beat_data(0, 0);
    check("t4 src c", m_src3, 0);
    check("t4 data c", m3.tdata[63:0], e[63:0]);
    step();
    s3.tvalid = '0;

    // Reset in the middle of a packet
    do_reset();
    pkts[0] = 1;
    len[0]  = 1;
    drive();
    #1;
    step();
    step();
    pkts[0] = 1;
    len[0]  = 4;
    drive();
    #1;
    step();
    check("t5 src", m_src2, 0);
    step();
    e = beat_data(0, 1);
    check("t5 beat2", m2.tdata[63:0], e[63:0]);
    #2;
    areset = 1'b0;
    #1;
    check("t5 rst busy", busy2, 0);
    check("t5 rst tvalid", m2.tvalid, 0);
    check("t5 rst tready", s2.tready, 0);
    check("t5 rst done", done2, 0);
    bidx[0] = 0;
    pkts[1] = 1;
    len[1]  = 1;
    @(posedge aclk);
    #1;
    areset = 1'b1;
    drive();
    #1;
    check("t5 bubble", m2.tvalid, 0);
    step();
    e = beat_data(0, 0);
    check("t5 regrant", m_src2, 0);
    check("t5 restart", m2.tdata[63:0], e[63:0]);

`ifdef CHK_ARB_WATCHDOG_EN
    // Mid-packet stall abort
    do_reset();
    pkts[0] = 1;
    len[0]  = 4;
    pkts[1] = 1;
    len[1]  = 1;
    drive();
    #1;
    step();
    check("t6 src", m_src2, 0);
    check("t6 beat1", m2.tvalid & m2.tready, 1);
    step();
    en[0] = 1'b0;
    drive();
    #1;
    for (int c = 0; c < WD; c++) begin
      check("t6 stall", m2.tvalid, 0);
      check("t6 wdog low", wdog_err2, 0);
      step();
    end
    check("t6 forced tvalid", m2.tvalid, 1);
    check("t6 forced tlast", m2.tlast, 1);
    check("t6 forced tkeep", m2.tkeep[63:0], 0);
    check("t6 forced tdata", m2.tdata[63:0], 0);
    check("t6 forced tid", m2.tid, 5);
    check("t6 forced tready", s2.tready, 0);
    check("t6 forced done", done2, 1);
    step();
    en[0] = 1'b1;
    drive();
    #1;
    check("t6 wdog set", wdog_err2, 1);
    check("t6 busy", busy2, 0);
    step();
    check("t6 next src", m_src2, 1);
    check("t6 wdog sticky", wdog_err2, 1);
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
